alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Sequencer that drives the shared 8-bit ALU (NOP/ADD/MUL/ACT) to compute one neuron output: y = ACT(sum of x[i]*w[i]) for i = 0..len-1.
- Sits between the operand stream source (input/weight buffers) and the result consumer.
- The ALU stays combinational and external; this block owns its op1/op2/alu_ctrl inputs and samples its result.

Parameters:
- LEN_W, 4, width of the vector-length field; maximum len = 2^LEN_W - 1.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  start pulse; honoured only in IDLE
- len  input  LEN_W  number of (x,w) pairs; sampled on an accepted start
- in_valid  input  1  operand pair valid
- in_x  input  8  input activation
- in_w  input  8  weight
- in_ready  output  1  block accepts a pair this cycle
- alu_op1  output  8  to ALU op1
- alu_op2  output  8  to ALU op2
- alu_ctrl  output  3  to ALU alu_ctrl
- alu_result  input  8  from ALU result
- out_valid  output  1  result available
- out_y  output  8  activated result (0 or 1)
- out_acc  output  8  pre-activation accumulator
- out_ready  input  1  consumer accepts result
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; acc, cnt, len_r, x_r, w_r, prod_r, out_y, out_acc = 0.
  - out_valid=0, in_ready=0, busy=0.
  - alu_ctrl=000, alu_op1=0, alu_op2=0.
  - Reset asserted mid-operation aborts the operation immediately; no partial result is produced.
- ALU outputs are combinational from the state and registers.
  - In IDLE, FETCH and DONE: alu_ctrl=000, op1=0, op2=0.
- State machine, with all registers updated on the rising clk edge:
  - IDLE:
    - start=1 and len>0: len_r<=len, acc<=0, cnt<=0, go to FETCH.
    - start=1 and len=0: acc<=0, go to ACT.
    - Otherwise stay in IDLE.
  - FETCH:
    - in_ready=1.
    - in_valid=1: x_r<=in_x, w_r<=in_w, go to MUL.
    - Otherwise wait in FETCH indefinitely.
  - MUL:
    - alu_ctrl=010, op1=x_r, op2=w_r.
    - prod_r<=alu_result (low 8 bits of the product), go to ADD.
  - ADD:
    - alu_ctrl=001, op1=acc, op2=prod_r.
    - acc<=alu_result (wraps mod 256), cnt<=cnt+1.
    - If cnt==len_r-1, go to ACT; otherwise go to FETCH.
  - ACT:
    - alu_ctrl=011, op1=acc, op2=0.
    - out_y<=alu_result, out_acc<=acc, go to DONE.
  - DONE:
    - out_valid=1; out_y and out_acc hold stable.
    - out_ready=1: out_valid drops on the next edge, go to IDLE.
- Arithmetic: all values are unsigned 8-bit; overflow wraps silently. ACT yields 1 when acc != 0, else 0.
- Latency with no stalls: start edge to out_valid = 3*len + 2 cycles; len=0 gives 2 cycles.
- Boundary rules:
  - start outside IDLE is ignored, including in DONE.
  - in_valid outside FETCH is ignored; the pair is not consumed.
  - A new start in the same cycle as the DONE->IDLE exit is ignored; start is accepted only from IDLE.
  - len is sampled only on the accepted start; later changes to len have no effect.
  - Reset wins over every other event.

Test Plan:
- Basic: len=3, pairs (1,4),(2,5),(3,6), in_valid always high, out_ready=1 -> out_acc=32, out_y=1, out_valid exactly 1 cycle, 11 cycles after start.
- Wrap: len=2, pairs (16,16),(0,9) -> MUL gives prod 0 each time, out_acc=0, out_y=0. Second case len=1, (20,13) -> 260 mod 256, out_acc=4, out_y=1.
- len=0: start -> no in_ready pulse, out_acc=0, out_y=0, out_valid 2 cycles after start.
- Stalls: in_valid low 5 cycles between pairs and out_ready low 4 cycles in DONE -> same result as the no-stall case; in_ready held high while stalled; outputs stable in DONE; busy high throughout.
- Ignored start: pulse start with len=7 during FETCH of a len=2 job -> job completes with 2 pairs; result unaffected.
- Reset mid-op: drop rst_n during ADD of pair 2 -> all outputs zero immediately. After release, a new len=1 job (3,3) gives out_acc=9, out_y=1.

Source files
------------

// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: operand stream, ALU drive and result handshake of the neuron sequencer.
interface alu_seq_ctrl_if #(parameter int LEN_W = 4);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic [7:0]       in_x;
    logic [7:0]       in_w;
    logic             in_ready;
    logic [7:0]       alu_op1;
    logic [7:0]       alu_op2;
    logic [2:0]       alu_ctrl;
    logic [7:0]       alu_result;
    logic             out_valid;
    logic [7:0]       out_y;
    logic [7:0]       out_acc;
    logic             out_ready;
    logic             busy;
    modport slave (
        input  start, len, in_valid, in_x, in_w, alu_result, out_ready,
        output in_ready, alu_op1, alu_op2, alu_ctrl, out_valid, out_y, out_acc, busy
    );
    modport master (
        output start, len, in_valid, in_x, in_w, alu_result, out_ready,
        input  in_ready, alu_op1, alu_op2, alu_ctrl, out_valid, out_y, out_acc, busy
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: drives a shared combinational 8-bit ALU to compute y = ACT(sum x[i]*w[i]).
module alu_seq_ctrl #(parameter int LEN_W = 4) (
    input logic          clk,
    input logic          rst_n,
    alu_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FETCH, MUL, ADD, ACT, DONE} state_t;
    state_t           state_q;
    logic [LEN_W-1:0] len_q, cnt_q;
    logic [7:0]       acc_q, x_q, w_q, prod_q, y_q, out_acc_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            x_q       <= '0;
            w_q       <= '0;
            prod_q    <= '0;
            y_q       <= '0;
            out_acc_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    acc_q <= '0;
                    if (bus.len != '0) begin
                        len_q   <= bus.len;
                        cnt_q   <= '0;
                        state_q <= FETCH;
                    end else begin
                        state_q <= ACT;
                    end
                end
                FETCH: if (bus.in_valid) begin
                    x_q     <= bus.in_x;
                    w_q     <= bus.in_w;
                    state_q <= MUL;
                end
                MUL: begin
                    prod_q  <= bus.alu_result;
                    state_q <= ADD;
                end
                ADD: begin
                    acc_q   <= bus.alu_result;
                    cnt_q   <= cnt_q + 1'b1;
                    state_q <= (cnt_q == len_q - 1'b1) ? ACT : FETCH;
                end
                ACT: begin
                    y_q       <= bus.alu_result;
                    out_acc_q <= acc_q;
                    state_q   <= DONE;
                end
                DONE: if (bus.out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    // ALU operands are decoded straight from the state so the ALU settles within the cycle
    always_comb begin
        bus.alu_ctrl = (state_q == MUL) ? 3'b010 :
                       (state_q == ADD) ? 3'b001 :
                       (state_q == ACT) ? 3'b011 : 3'b000;
        bus.alu_op1  = (state_q == MUL) ? x_q :
                       (state_q == ADD || state_q == ACT) ? acc_q : 8'd0;
        bus.alu_op2  = (state_q == MUL) ? w_q :
                       (state_q == ADD) ? prod_q : 8'd0;
    end
    assign bus.in_ready  = (state_q == FETCH);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_y     = y_q;
    assign bus.out_acc   = out_acc_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: table-driven neuron jobs plus hand sequences for stalls, ignored starts and reset.
module tb_alu_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    alu_seq_ctrl_if #(.LEN_W(4)) b ();
    alu_seq_ctrl #(.LEN_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
    always #5 clk = ~clk;
    // reference model of the external ALU
    always_comb begin
        b.alu_result = (b.alu_ctrl == 3'b001) ? 8'(b.alu_op1 + b.alu_op2) :
                       (b.alu_ctrl == 3'b010) ? 8'(b.alu_op1 * b.alu_op2) :
                       (b.alu_ctrl == 3'b011) ? {7'd0, b.alu_op1 != 8'd0} : 8'd0;
    end
    typedef struct packed {
        logic [3:0]       l;
        logic [14:0][7:0] x;
        logic [14:0][7:0] w;
        logic [7:0]       a;
        logic [7:0]       y;
    } vec_t;
    vec_t v [8];
    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction
    task automatic job(input string nm, input logic [3:0] l, input logic [14:0][7:0] xs,
                       input logic [14:0][7:0] ws, input int ist, input int ost, input int sp,
                       input bit ds, input logic [7:0] ea, input logic [7:0] ey);
        int e = 0, p = 0, st = ist, ovc = 0, irc = 0, lat = -1;
        bit took = 0, done = 0, bb = 0, sb = 0;
        @(negedge clk);
        b.len = l; b.start = 1'b1; b.out_ready = 1'b0; b.in_valid = 1'b0;
        while (!done && e < 600) begin
            @(posedge clk);
            e++;
            if (took) begin p++; st = ist; end
            @(negedge clk);
            b.start = (e == sp);
            b.len = (e == sp) ? 4'd7 : ~l;
            if (b.out_valid) begin
                if (ovc == 0) begin
                    lat = e;
                    chk({nm, "_acc"}, 32'(b.out_acc), 32'(ea));
                    chk({nm, "_y"}, 32'(b.out_y), 32'(ey));
                end else if (b.out_acc !== ea || b.out_y !== ey) sb = 1;
                ovc++;
                b.out_ready = (ovc > ost);
                if (b.out_ready && ds) begin b.start = 1'b1; b.len = 4'd1; end
            end else if (ovc > 0) done = 1;
            if (!done && !b.busy) bb = 1;
            if (b.in_ready) irc++;
            took = 0;
            if (b.in_ready && st > 0) begin b.in_valid = 1'b0; st--; end
            else if (b.in_ready) begin b.in_valid = 1'b1; b.in_x = xs[p]; b.in_w = ws[p]; took = 1; end
            else b.in_valid = 1'b0;
        end
        chk({nm, "_finished"}, 32'(done), 32'd1);
        chk({nm, "_latency"}, lat, 3 * int'(l) + 2 + int'(l) * ist);
        chk({nm, "_pairs"}, p, int'(l));
        chk({nm, "_in_ready_cycles"}, irc, int'(l) * (ist + 1));
        chk({nm, "_out_valid_cycles"}, ovc, ost + 1);
        chk({nm, "_out_stable"}, 32'(sb), 32'd0);
        chk({nm, "_busy_during"}, 32'(bb), 32'd0);
        chk({nm, "_busy_after"}, 32'(b.busy), 32'd0);
        b.start = 1'b0; b.out_ready = 1'b0; b.in_valid = 1'b0;
    endtask
    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
    initial begin
        b.start = 1'b0; b.len = '0; b.in_valid = 1'b0; b.in_x = '0; b.in_w = '0; b.out_ready = 1'b0;
        v[0] = '{4'd3, 120'({8'd3, 8'd2, 8'd1}), 120'({8'd6, 8'd5, 8'd4}), 8'd32, 8'd1};
        v[1] = '{4'd2, 120'({8'd0, 8'd16}), 120'({8'd9, 8'd16}), 8'd0, 8'd0};
        v[2] = '{4'd1, 120'(8'd20), 120'(8'd13), 8'd4, 8'd1};
        v[3] = '{4'd0, 120'd0, 120'd0, 8'd0, 8'd0};
        v[4] = '{4'd2, 120'({8'd100, 8'd200}), 120'({8'd1, 8'd1}), 8'd44, 8'd1};
        v[5] = '{4'd15, {15{8'd1}}, {15{8'd1}}, 8'd15, 8'd1};
        v[6] = '{4'd2, 120'({8'd255, 8'd255}), 120'({8'd255, 8'd255}), 8'd2, 8'd1};
        v[7] = '{4'd4, 120'({8'd10, 8'd0, 8'd7, 8'd3}), 120'({8'd10, 8'd0, 8'd2, 8'd5}), 8'd129, 8'd1};
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(b.busy), 32'd0);
        chk("rst_in_ready", 32'(b.in_ready), 32'd0);
        chk("rst_out_valid", 32'(b.out_valid), 32'd0);
        chk("rst_alu", 32'({b.alu_ctrl, b.alu_op1, b.alu_op2}), 32'd0);
        chk("rst_out", 32'({b.out_y, b.out_acc}), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++)
            job($sformatf("vec%0d", i), v[i].l, v[i].x, v[i].w, 0, 0, -1, 1'b0, v[i].a, v[i].y);
        job("stall", v[0].l, v[0].x, v[0].w, 5, 4, -1, 1'b0, 8'd32, 8'd1);
        job("ign_start", 4'd2, 120'({8'd4, 8'd2}), 120'({8'd5, 8'd3}), 0, 0, 1, 1'b0, 8'd26, 8'd1);
        job("done_start", v[0].l, v[0].x, v[0].w, 0, 0, -1, 1'b1, 8'd32, 8'd1);
        @(negedge clk);
        chk("done_start_idle", 32'(b.busy), 32'd0);
        b.start = 1'b1; b.len = 4'd2; b.in_valid = 1'b1; b.in_x = 8'd1; b.in_w = 8'd1; b.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            b.start = 1'b0;
            if (i == 1) begin b.in_x = 8'd2; b.in_w = 8'd2; end
        end
        chk("mid_add_ctrl", 32'(b.alu_ctrl), 32'd1);
        chk("mid_add_ops", 32'({b.alu_op1, b.alu_op2}), 32'({8'd1, 8'd4}));
        b.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_alu", 32'({b.alu_ctrl, b.alu_op1, b.alu_op2}), 32'd0);
        chk("mid_rst_flags", 32'({b.busy, b.in_ready, b.out_valid}), 32'd0);
        chk("mid_rst_out", 32'({b.out_y, b.out_acc}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        job("post_rst", 4'd1, 120'(8'd3), 120'(8'd3), 0, 0, -1, 1'b0, 8'd9, 8'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
